// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a shared RV32I ALU.
// Define ALU_ARB_OPCHECK_EN to reject illegal opcodes with an error response.
module alu_share_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_op,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_s,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic             prio;
  logic             gnt;
  logic             sel;
  logic             accept;
  logic             rsp_hs;
  logic [WIDTH-1:0] result;
  logic             err_q;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [3:0]       in_op;

  // Requester 1 wins when alone or when the pointer favours it.
  always_comb begin
    sel    = req1_valid & (~req0_valid | prio);
    accept = (state == IDLE) & ~rst & (req0_valid | req1_valid);
    in_a   = sel ? req1_a  : req0_a;
    in_b   = sel ? req1_b  : req0_b;
    in_op  = sel ? req1_op : req0_op;
    rsp_hs = (state == RESP) & (gnt ? rsp1_ready : rsp0_ready);
  end

  assign req0_ready = accept & ~sel;
  assign req1_ready = accept &  sel;

  assign rsp0_valid = (state == RESP) & ~gnt;
  assign rsp1_valid = (state == RESP) &  gnt;
  assign rsp0_data  = result;
  assign rsp1_data  = result;
  assign rsp0_err   = err_q;
  assign rsp1_err   = err_q;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      state == IDLE:  if (accept) state_nx = ISSUE;
      state == ISSUE: state_nx = RESP;
      state == RESP:  if (rsp_hs) state_nx = IDLE;
      default:        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
      gnt   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        gnt  <= sel;
        prio <= ~sel;
      end
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic bad;
  logic bad_q;

  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    unique case (op)
      4'b0000, 4'b1000, 4'b0001, 4'b0010,
      4'b0011, 4'b0100, 4'b0101, 4'b1101,
      4'b0110, 4'b0111: ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign bad = ~op_legal(in_op);

  // Illegal ops still take the ISSUE slot so latency stays fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= 4'b0000;
      bad_q  <= 1'b0;
      result <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        alu_a  <= in_a;
        alu_b  <= in_b;
        alu_op <= bad ? 4'b0000 : in_op;
        bad_q  <= bad;
      end
      if (state == ISSUE) begin
        result <= bad_q ? '0 : alu_s;
        err_q  <= bad_q;
      end
    end
  end
`else
  assign err_q = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= 4'b0000;
      result <= '0;
    end else begin
      if (accept) begin
        alu_a  <= in_a;
        alu_b  <= in_b;
        alu_op <= in_op;
      end
      if (state == ISSUE) result <= alu_s;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU on alu_*.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_err;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_err;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] alu_a, alu_b, alu_s;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU; unknown codes return a marker value.
  always_comb begin
    case (alu_op)
      4'b0000: alu_s = alu_a + alu_b;
      4'b1000: alu_s = alu_a - alu_b;
      4'b0001: alu_s = alu_a << alu_b[4:0];
      4'b0010: alu_s = {31'b0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_s = {31'b0, alu_a < alu_b};
      4'b0100: alu_s = alu_a ^ alu_b;
      4'b0101: alu_s = alu_a >> alu_b[4:0];
      4'b1101: alu_s = $signed(alu_a) >>> alu_b[4:0];
      4'b0110: alu_s = alu_a | alu_b;
      4'b0111: alu_s = alu_a & alu_b;
      default: alu_s = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] a0 [3] = '{32'hFFFF_FFFB, 32'h0000_00F0, 32'h8000_0000};
  logic [31:0] b0 [3] = '{32'd3, 32'h0000_00FF, 32'd4};
  logic [3:0]  o0 [3] = '{4'b0010, 4'b0100, 4'b0101};
  logic [31:0] a1 [3] = '{32'd5, 32'h0000_00F0, 32'h0000_00FF};
  logic [31:0] b1 [3] = '{32'd3, 32'h0000_000F, 32'h0000_003C};
  logic [3:0]  o1 [3] = '{4'b0011, 4'b0110, 4'b0111};
  logic [31:0] e4 [6] = '{32'd1, 32'd0, 32'h0F, 32'hFF,
                          32'h0800_0000, 32'h3C};

  initial begin
    int i0, i1, g, n;
    rst = 1'b1;
    req0_valid = 1'b1; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 1'b0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready0", {31'b0, req0_ready}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'b0, rsp1_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {28'b0, alu_op}, 32'd0);
    chk("rst_rsp0_data", rsp0_data, 32'd0);

    // Single requester 0: 5 + 3
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 5; req0_b = 3; req0_op = 4'b0000;
    @(negedge clk);
    chk("t1_ready0", {31'b0, req0_ready}, 32'd1);
    chk("t1_ready1", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("t1_issue_busy", {31'b0, busy}, 32'd1);
    chk("t1_alu_a", alu_a, 32'd5);
    chk("t1_alu_b", alu_b, 32'd3);
    chk("t1_early_valid", {31'b0, rsp0_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t1_rsp_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("t1_rsp_data", rsp0_data, 32'd8);
    chk("t1_rsp_err", {31'b0, rsp0_err}, 32'd0);
    chk("t1_rsp1_quiet", {31'b0, rsp1_valid}, 32'd0);
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    rsp0_ready = 1'b0;
    @(negedge clk);
    chk("t1_done_busy", {31'b0, busy}, 32'd0);
    chk("t1_done_valid", {31'b0, rsp0_valid}, 32'd0);

    // Both valid after reset: req0 SUB then req1 SLL
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 8; req0_b = 3; req0_op = 4'b1000;
    req1_valid = 1'b1; req1_a = 4; req1_b = 2; req1_op = 4'b0001;
    @(negedge clk);
    chk("t2_first_ready0", {31'b0, req0_ready}, 32'd1);
    chk("t2_first_ready1", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    chk("t2_issue_ready1", {31'b0, req1_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t2_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("t2_rsp0_data", rsp0_data, 32'd5);
    chk("t2_rsp1_low", {31'b0, rsp1_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("t2_second_ready1", {31'b0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t2_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
    chk("t2_rsp1_data", rsp1_data, 32'd16);
    @(posedge clk); #1;

    // Back-pressure on requester 1 SRA
    rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'hFFFF_FFF8; req1_b = 2; req1_op = 4'b1101;
    @(negedge clk);
    chk("t3_ready1", {31'b0, req1_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 1; req0_b = 1; req0_op = 4'b0000;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_hold_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("t3_hold_data", rsp1_data, 32'hFFFF_FFFE);
      chk("t3_hold_busy", {31'b0, busy}, 32'd1);
      chk("t3_block_ready0", {31'b0, req0_ready}, 32'd0);
      @(posedge clk);
    end
    #1 rsp1_ready = 1'b1;
    @(negedge clk);
    chk("t3_last_valid", {31'b0, rsp1_valid}, 32'd1);
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    @(negedge clk);
    chk("t3_after_ready0", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t3_rsp0_data", rsp0_data, 32'd2);
    @(posedge clk); #1;

    // Continuous traffic from both, six transactions
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    i0 = 0; i1 = 0;
    req0_valid = 1'b1; req0_a = a0[0]; req0_b = b0[0]; req0_op = o0[0];
    req1_valid = 1'b1; req1_a = a1[0]; req1_b = b1[0]; req1_op = o1[0];
    for (int k = 0; k < 6; k++) begin
      g = k % 2;
      n = 0;
      @(negedge clk);
      while (!(req0_ready || req1_ready) && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("t4_any_ready", {31'b0, req0_ready | req1_ready}, 32'd1);
      chk("t4_grant", {31'b0, req1_ready}, g);
      @(posedge clk); #1;
      if (g == 0) begin
        i0++;
        if (i0 < 3) begin
          req0_a = a0[i0]; req0_b = b0[i0]; req0_op = o0[i0];
        end else req0_valid = 1'b0;
      end else begin
        i1++;
        if (i1 < 3) begin
          req1_a = a1[i1]; req1_b = b1[i1]; req1_op = o1[i1];
        end else req1_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("t4_rsp_valid", {31'b0, g ? rsp1_valid : rsp0_valid}, 32'd1);
      chk("t4_rsp_data", g ? rsp1_data : rsp0_data, e4[k]);
      @(posedge clk);
    end

    // Reset during ISSUE discards the request
    #1;
    req0_valid = 1'b1; req0_a = 1; req0_b = 2; req0_op = 4'b0000;
    @(negedge clk);
    chk("t5_ready0", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t5_issue_busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_rsp0_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("t5_alu_a", alu_a, 32'd0);
    chk("t5_rsp0_data", rsp0_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", {31'b0, rsp0_valid | rsp1_valid}, 32'd0);
    end
    @(posedge clk); #1;

    // Illegal opcode 1111
    req0_valid = 1'b1; req0_a = 7; req0_b = 9; req0_op = 4'b1111;
    @(negedge clk);
    chk("t6_ready0", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    @(negedge clk);
`ifdef ALU_ARB_OPCHECK_EN
    chk("t6_alu_op", {28'b0, alu_op}, 32'd0);
`else
    chk("t6_alu_op", {28'b0, alu_op}, 32'd15);
`endif
    @(posedge clk);
    @(negedge clk);
    chk("t6_rsp_valid", {31'b0, rsp0_valid}, 32'd1);
`ifdef ALU_ARB_OPCHECK_EN
    chk("t6_rsp_data", rsp0_data, 32'd0);
    chk("t6_rsp_err", {31'b0, rsp0_err}, 32'd1);
`else
    chk("t6_rsp_data", rsp0_data, 32'hDEAD_BEEF);
    chk("t6_rsp_err", {31'b0, rsp0_err}, 32'd0);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("t6_done_busy", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
